ps2_scancode_tx: RTL and testbench

//  Device-side PS/2 transmitter: serialises an 8-bit set-2 scan code onto ps2_clk/ps2_data.
//  - Makes the design self-test the keyboard receive path and the scan-code-to-7-segment

---
 rtl/ps2_scancode_tx.sv | 151 +++++++++++++++
 tb/tb_ps2_scancode_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_tx.sv
// ps2_scancode_tx
// Device-side PS/2 transmitter. Serialises a latched set-2 scan code as an
// 11-bit frame (start, d0..d7, odd parity, stop) on ps2_clk/ps2_data, and
// optionally follows it with the break sequence F0, code, separated by idle
// gaps. Used as a keyboard emulator for loopback testing of a PS/2 receive path.
module ps2_scancode_tx #(
   parameter int CLK_DIV    = 2500,
   parameter int GAP_HALVES = 4,
   parameter int SEND_BREAK = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] scancode,
   output logic       busy,
   output logic       done,
   output logic       ps2_clk,
   output logic       ps2_data
);

   // Counter is sized for the longest interval it must time (the inter-byte gap).
   localparam int CW = $clog2(CLK_DIV * GAP_HALVES) + 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(CLK_DIV * GAP_HALVES - 1);
   // Index of the final byte of a sequence: code only, or code, F0, code.
   localparam logic [1:0]    LAST_BYTE = (SEND_BREAK != 0) ? 2'd2 : 2'd0;
   localparam logic [3:0]    STOP_BIT  = 4'd10;

   typedef enum logic [2:0] {IDLE, HI, LO, GAP, FIN} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [3:0]      bit_idx_reg, bit_idx_next;
   logic [1:0]      byte_idx_reg, byte_idx_next;
   logic [7:0]      code_reg, code_next;
   logic            ps2_clk_reg, ps2_clk_next;
   logic            ps2_data_reg, ps2_data_next;

   logic [7:0]      cur_byte;
   logic [10:0]     frame_bits;
   logic [3:0]      bit_inc;

   // Byte 1 of a make/break sequence is the F0 prefix; the others are the latched code.
   assign cur_byte   = (byte_idx_reg == 2'd1) ? 8'hF0 : code_reg;
   // frame_bits[i] is the value driven during bit i of the frame.
   assign frame_bits = {1'b1, ~^cur_byte, cur_byte, 1'b0};
   assign bit_inc    = bit_idx_reg + 4'd1;

   assign busy     = (state_reg != IDLE);
   assign done     = (state_reg == FIN);
   assign ps2_clk  = ps2_clk_reg;
   assign ps2_data = ps2_data_reg;

   // State, counters and registered line drivers; reset forces idle lines at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         bit_idx_reg  <= '0;
         byte_idx_reg <= '0;
         code_reg     <= '0;
         ps2_clk_reg  <= 1'b1;
         ps2_data_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         bit_idx_reg  <= bit_idx_next;
         byte_idx_reg <= byte_idx_next;
         code_reg     <= code_next;
         ps2_clk_reg  <= ps2_clk_next;
         ps2_data_reg <= ps2_data_next;
      end
   end

   // Next-state logic: half-period sequencing, bit/byte stepping and line values.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      bit_idx_next  = bit_idx_reg;
      byte_idx_next = byte_idx_reg;
      code_next     = code_reg;
      ps2_clk_next  = ps2_clk_reg;
      ps2_data_next = ps2_data_reg;

      case (state_reg)
         IDLE: begin
            ps2_clk_next  = 1'b1;
            ps2_data_next = 1'b1;
            cnt_next      = '0;
            if (start) begin
               code_next     = scancode;
               byte_idx_next = 2'd0;
               bit_idx_next  = 4'd0;
               ps2_data_next = 1'b0;     // start bit
               state_next    = HI;
            end
         end

         HI: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next     = '0;
               ps2_clk_next = 1'b0;      // receiver samples on this fall
               state_next   = LO;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end

         LO: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next     = '0;
               ps2_clk_next = 1'b1;
               if (bit_idx_reg < STOP_BIT) begin
                  // Data only moves while the clock is high.
                  bit_idx_next  = bit_inc;
                  ps2_data_next = frame_bits[bit_inc];
                  state_next    = HI;
               end else begin
                  ps2_data_next = 1'b1;
                  state_next    = (byte_idx_reg == LAST_BYTE) ? FIN : GAP;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end

         GAP: begin
            if (cnt_reg == GAP_LAST) begin
               cnt_next      = '0;
               byte_idx_next = byte_idx_reg + 2'd1;
               bit_idx_next  = 4'd0;
               ps2_data_next = 1'b0;     // start bit of the next byte
               state_next    = HI;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end

         FIN: begin
            state_next = IDLE;
         end

         default: begin
            state_next    = IDLE;
            ps2_clk_next  = 1'b1;
            ps2_data_next = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_ps2_scancode_tx.sv
// Testbench for ps2_scancode_tx: two instances (code only, and make/break),
// PS/2 frame capture on the falling edge of ps2_clk, table-driven frame checks
// and hand-written sequences for the multi-cycle corner cases.
module tb_ps2_scancode_tx;

   logic       clk;
   logic       reset;
   logic       start0, start1;
   logic [7:0] scancode;
   logic       busy0, done0, ps2_clk0, ps2_data0;
   logic       busy1, done1, ps2_clk1, ps2_data1;

   int n_cmp = 0;
   int n_err = 0;

   ps2_scancode_tx #(.CLK_DIV(4), .GAP_HALVES(4), .SEND_BREAK(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .scancode(scancode),
      .busy(busy0), .done(done0), .ps2_clk(ps2_clk0), .ps2_data(ps2_data0)
   );

   ps2_scancode_tx #(.CLK_DIV(4), .GAP_HALVES(4), .SEND_BREAK(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .scancode(scancode),
      .busy(busy1), .done(done1), .ps2_clk(ps2_clk1), .ps2_data(ps2_data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Captured frames, bit i of each entry = i-th bit seen on a ps2_clk fall.
   logic [10:0] q0[$];
   logic [10:0] q1[$];
   logic [10:0] sh0, sh1;
   int          nb0, nb1;

   always @(negedge ps2_clk0 or posedge reset) begin
      if (reset) begin
         nb0 = 0;
      end else begin
         sh0 = {ps2_data0, sh0[10:1]};
         nb0++;
         if (nb0 == 11) begin
            q0.push_back(sh0);
            nb0 = 0;
         end
      end
   end

   always @(negedge ps2_clk1 or posedge reset) begin
      if (reset) begin
         nb1 = 0;
      end else begin
         sh1 = {ps2_data1, sh1[10:1]};
         nb1++;
         if (nb1 == 11) begin
            q1.push_back(sh1);
            nb1 = 0;
         end
      end
   end

   int done0_cnt = 0;
   int done1_cnt = 0;
   always @(posedge clk) begin
      if (done0) done0_cnt++;
      if (done1) done1_cnt++;
   end

   // Runs of idle-looking cycles (clk=1, data=1) while dut1 is busy.
   int run1 = 0, gap16_cnt = 0, run_max = 0;
   always @(negedge clk) begin
      if (!busy1) begin
         run1 = 0;
      end else if (ps2_clk1 && ps2_data1) begin
         run1++;
      end else begin
         if (run1 == 16) gap16_cnt++;
         if (run1 > run_max) run_max = run1;
         run1 = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Drive a one-cycle start; returns at the negedge after the accepting edge.
   task automatic start_dut(input int which, input logic [7:0] code);
      @(negedge clk);
      scancode = code;
      if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_done(input int which, input int budget, output int n);
      n = 0;
      while (n < budget && !((which == 0) ? done0 : done1)) begin
         @(negedge clk);
         n++;
      end
   endtask

   typedef struct packed {
      logic [7:0]  code;
      logic [10:0] frame;
   } vec_t;

   vec_t vecs[8];

   logic [7:0] keys[36] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
      8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
      8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26,
      8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
   };

   logic [10:0] f_1c, f_f0, f_45, got;
   int          n, d_before;

   initial begin
      // {stop, parity, data, start}; parity hand-computed for odd total ones.
      vecs[0] = '{8'h1C, {1'b1, 1'b0, 8'h1C, 1'b0}};
      vecs[1] = '{8'h00, {1'b1, 1'b1, 8'h00, 1'b0}};
      vecs[2] = '{8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}};
      vecs[3] = '{8'h32, {1'b1, 1'b0, 8'h32, 1'b0}};
      vecs[4] = '{8'h55, {1'b1, 1'b1, 8'h55, 1'b0}};
      vecs[5] = '{8'h80, {1'b1, 1'b0, 8'h80, 1'b0}};
      vecs[6] = '{8'h01, {1'b1, 1'b0, 8'h01, 1'b0}};
      vecs[7] = '{8'hE7, {1'b1, 1'b1, 8'hE7, 1'b0}};
      f_1c = 11'b1_0_00011100_0;   // bits 0,0,0,1,1,1,0,0,0,0,1 from LSB
      f_f0 = {1'b1, 1'b1, 8'hF0, 1'b0};
      f_45 = {1'b1, 1'b0, 8'h45, 1'b0};

      reset = 1'b1; start0 = 1'b0; start1 = 1'b0; scancode = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ps2_clk", {31'd0, ps2_clk0}, 32'd1);
      check("rst_ps2_data", {31'd0, ps2_data0}, 32'd1);
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_done", {31'd0, done0}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single frames with code only.
      for (int i = 0; i < 8; i++) begin
         q0.delete();
         start_dut(0, vecs[i].code);
         check("vec_busy_rise", {31'd0, busy0}, 32'd1);
         wait_done(0, 200, n);
         check("vec_latency", n, 88);
         @(negedge clk);
         check("vec_busy_fall", {31'd0, busy0}, 32'd0);
         check("vec_idle_lines", {30'd0, ps2_clk0, ps2_data0}, 32'd3);
         got = (q0.size() != 0) ? q0.pop_front() : 11'h000;
         check("vec_frame", {21'd0, got}, {21'd0, vecs[i].frame});
         $display("vec %0d code=%02h frame=%03h lat=%0d", i, vecs[i].code, got, n);
      end

      // Make/break sequence.
      q1.delete();
      d_before = done1_cnt;
      gap16_cnt = 0; run_max = 0;
      start_dut(1, 8'h1C);
      wait_done(1, 600, n);
      check("brk_latency", n, 296);
      repeat (3) @(negedge clk);
      check("brk_done_pulses", done1_cnt - d_before, 1);
      check("brk_nframes", q1.size(), 3);
      got = (q1.size() != 0) ? q1.pop_front() : 11'h000;
      check("brk_frame0", {21'd0, got}, {21'd0, f_1c});
      got = (q1.size() != 0) ? q1.pop_front() : 11'h000;
      check("brk_frame1", {21'd0, got}, {21'd0, f_f0});
      got = (q1.size() != 0) ? q1.pop_front() : 11'h000;
      check("brk_frame2", {21'd0, got}, {21'd0, f_1c});
      check("brk_gaps16", gap16_cnt, 2);
      check("brk_run_max", run_max, 16);
      $display("break seq code=1C lat=%0d gaps=%0d", n, gap16_cnt);

      // Start pulsed again mid-frame.
      q0.delete();
      start_dut(0, 8'h1C);
      repeat (30) @(negedge clk);
      start_dut(0, 8'h32);
      check("mid_busy", {31'd0, busy0}, 32'd1);
      wait_done(0, 200, n);
      check("mid_latency", n, 56);
      @(negedge clk);
      got = (q0.size() != 0) ? q0.pop_front() : 11'h000;
      check("mid_frame", {21'd0, got}, {21'd0, f_1c});
      check("mid_nframes", q0.size(), 0);
      $display("mid-start code=1C frame=%03h", got);

      // Reset during bit 5 (low half), off the clock edge.
      q0.delete();
      d_before = done0_cnt;
      start_dut(0, 8'h1C);
      repeat (44) @(negedge clk);
      check("rst_pre_lo", {31'd0, ps2_clk0}, 32'd0);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_clk", {31'd0, ps2_clk0}, 32'd1);
      check("rst_mid_data", {31'd0, ps2_data0}, 32'd1);
      check("rst_mid_busy", {31'd0, busy0}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      check("rst_no_done", done0_cnt - d_before, 0);
      check("rst_no_frame", q0.size(), 0);
      start_dut(0, 8'h1C);
      wait_done(0, 200, n);
      check("rst_after_lat", n, 88);
      @(negedge clk);
      got = (q0.size() != 0) ? q0.pop_front() : 11'h000;
      check("rst_after_frame", {21'd0, got}, {21'd0, f_1c});
      $display("reset mid-frame, resend frame=%03h", got);

      // Start held high across the end of a sequence.
      q0.delete();
      @(negedge clk);
      scancode = 8'h45;
      start0 = 1'b1;
      @(negedge clk);
      wait_done(0, 200, n);
      check("held_lat", n, 88);
      @(negedge clk);
      check("held_idle_cycle", {31'd0, busy0}, 32'd0);
      @(negedge clk);
      check("held_restart", {31'd0, busy0}, 32'd1);
      start0 = 1'b0;
      wait_done(0, 200, n);
      check("held_lat2", n, 88);
      @(negedge clk);
      check("held_nframes", q0.size(), 2);
      got = (q0.size() != 0) ? q0.pop_front() : 11'h000;
      check("held_frame0", {21'd0, got}, {21'd0, f_45});
      got = (q0.size() != 0) ? q0.pop_front() : 11'h000;
      check("held_frame1", {21'd0, got}, {21'd0, f_45});
      $display("held start code=45 two frames sent");

      // Loopback of all letter/digit codes through a frame decoder.
      for (int k = 0; k < 36; k++) begin
         q0.delete();
         start_dut(0, keys[k]);
         wait_done(0, 200, n);
         @(negedge clk);
         got = (q0.size() != 0) ? q0.pop_front() : 11'h000;
         check("lb_byte", {24'd0, got[8:1]}, {24'd0, keys[k]});
         check("lb_framing", {29'd0, got[10], got[0], ^got[9:1]}, 32'd5);
         $display("loopback %0d sent=%02h recv=%02h", k, keys[k], got[8:1]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
